// File: rtl/stopwatch_ctrl.sv
// MM:SS BCD stopwatch sequencer: button synchronizers, 1 Hz prescaler, run FSM and digit cascade.
// Optional lap-hold display feature is compiled in when LAP_EN is defined.
//
// state | meaning
// IDLE  | stopped at 00:00, prescaler cleared
// RUN   | prescaler counting, digits advance on each tick
// PAUSE | prescaler and digits frozen, fractional second kept
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SYNC_STG = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_ss_n,
    input  logic       key_clr_n,
    input  logic       key_lap_n,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [3:0]          s1_q, s10_q, m1_q, m10_q;
    logic                running_q, wrap_q;
    logic [SYNC_STG-1:0] ss_sync_q, clr_sync_q;
    logic                ss_prev_q, clr_prev_q;
    logic                ss_press, clr_press;
    logic                tick, c_s1, c_s10, c_m1, c_m10;

    // Released buttons read high, so the synchronizers reset to 1 to avoid a false press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_sync_q  <= '1;
            clr_sync_q <= '1;
            ss_prev_q  <= 1'b1;
            clr_prev_q <= 1'b1;
        end else begin
            ss_sync_q  <= {ss_sync_q[SYNC_STG-2:0], key_ss_n};
            clr_sync_q <= {clr_sync_q[SYNC_STG-2:0], key_clr_n};
            ss_prev_q  <= ss_sync_q[SYNC_STG-1];
            clr_prev_q <= clr_sync_q[SYNC_STG-1];
        end
    end

    assign ss_press  = ss_prev_q & ~ss_sync_q[SYNC_STG-1];
    assign clr_press = clr_prev_q & ~clr_sync_q[SYNC_STG-1];

    assign tick  = (state_q == RUN) && (cnt_q == CW'(TICK_DIV - 1));
    assign c_s1  = (s1_q == 4'd9);
    assign c_s10 = c_s1 && (s10_q == 4'd5);
    assign c_m1  = c_s10 && (m1_q == 4'd9);
    assign c_m10 = c_m1 && (m10_q == 4'd5);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s1_q      <= '0;
            s10_q     <= '0;
            m1_q      <= '0;
            m10_q     <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ss_press) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                RUN: begin
                    cnt_q <= tick ? '0 : cnt_q + CW'(1);
                    if (tick) begin
                        s1_q <= c_s1 ? 4'd0 : s1_q + 4'd1;
                        if (c_s1)  s10_q <= c_s10 ? 4'd0 : s10_q + 4'd1;
                        if (c_s10) m1_q  <= c_m1  ? 4'd0 : m1_q + 4'd1;
                        if (c_m1)  m10_q <= c_m10 ? 4'd0 : m10_q + 4'd1;
                        wrap_q <= c_m10;
                    end
                    if (ss_press) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (clr_press) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        s1_q    <= '0;
                        s10_q   <= '0;
                        m1_q    <= '0;
                        m10_q   <= '0;
                    end else if (ss_press) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign running = running_q;
    assign wrap    = wrap_q;

`ifdef LAP_EN
    logic [SYNC_STG-1:0] lap_sync_q;
    logic                lap_prev_q, lap_q, lap_press;
    logic [15:0]         snap_q;

    assign lap_press = lap_prev_q & ~lap_sync_q[SYNC_STG-1];

    // Leaving RUN (ss press) drops the latch on the same edge as the state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_sync_q <= '1;
            lap_prev_q <= 1'b1;
            lap_q      <= 1'b0;
            snap_q     <= '0;
        end else begin
            lap_sync_q <= {lap_sync_q[SYNC_STG-2:0], key_lap_n};
            lap_prev_q <= lap_sync_q[SYNC_STG-1];
            if (state_q != RUN || ss_press) begin
                lap_q <= 1'b0;
            end else if (lap_press) begin
                lap_q <= ~lap_q;
                if (!lap_q) snap_q <= {m10_q, m1_q, s10_q, s1_q};
            end
        end
    end

    assign sec_ones = lap_q ? snap_q[3:0]   : s1_q;
    assign sec_tens = lap_q ? snap_q[7:4]   : s10_q;
    assign min_ones = lap_q ? snap_q[11:8]  : m1_q;
    assign min_tens = lap_q ? snap_q[15:12] : m10_q;
`else
    logic unused_lap;
    assign unused_lap = key_lap_n;

    assign sec_ones = s1_q;
    assign sec_tens = s10_q;
    assign min_ones = m1_q;
    assign min_tens = m10_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboarded bench for stopwatch_ctrl (TICK_DIV=4, SYNC_STG=2); expectations are keyed to clock-edge count.
// Lap-hold expectations switch on LAP_EN.
module tb_stopwatch_ctrl;
`ifdef LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, key_ss_n, key_clr_n, key_lap_n;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, wrap;
    logic [15:0] dig;

    stopwatch_ctrl #(.TICK_DIV(4), .SYNC_STG(2)) dut (
        .clk(clk), .rst(rst),
        .key_ss_n(key_ss_n), .key_clr_n(key_clr_n), .key_lap_n(key_lap_n),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .wrap(wrap)
    );

    assign dig = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] dig;
        logic        run;
        logic        wrp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int c, input logic [15:0] d, input logic r,
                             input logic w, input string n);
        exp_t e;
        e.cyc = c; e.dig = d; e.run = r; e.wrp = w; e.name = n;
        sb.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: the DUT presents a fresh output every edge; compare whatever is due now.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || dig !== e.dig || running !== e.run || wrap !== e.wrp) begin
                    errors++;
                    $display("FAIL %s: got dig=%h run=%b wrap=%b at cyc %0d, want dig=%h run=%b wrap=%b at cyc %0d",
                             e.name, dig, running, wrap, cyc, e.dig, e.run, e.wrp, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: got cyc=%0d still running, want finish before 20000", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    int c0, b3, b;

    initial begin
        rst = 1'b0; key_ss_n = 1'b1; key_clr_n = 1'b1; key_lap_n = 1'b1;
        #1;
        checks++;
        if (dig !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_immediate: got dig=%h run=%b wrap=%b, want dig=0000 run=0 wrap=0",
                     dig, running, wrap);
        end
        goto(2);
        expect_at(2, 16'h0000, 1'b0, 1'b0, "reset_state");
        rst = 1'b1;

        // start from IDLE, hold ss
        goto(4);
        c0 = cyc;
        expect_at(c0 + 2,  16'h0000, 1'b0, 1'b0, "ss_sync_delay");
        expect_at(c0 + 3,  16'h0000, 1'b1, 1'b0, "ss_start");
        expect_at(c0 + 6,  16'h0000, 1'b1, 1'b0, "first_sec_pending");
        expect_at(c0 + 7,  16'h0001, 1'b1, 1'b0, "first_tick");
        expect_at(c0 + 42, 16'h0009, 1'b1, 1'b0, "nine_sec");
        expect_at(c0 + 43, 16'h0010, 1'b1, 1'b0, "ten_sec_carry");
        key_ss_n = 1'b0;
        goto(c0 + 20);
        key_ss_n = 1'b1;

        // pause with prescaler at 2, resume 20+ cycles later
        expect_at(c0 + 47, 16'h0011, 1'b1, 1'b0, "pre_pause");
        expect_at(c0 + 50, 16'h0011, 1'b0, 1'b0, "pause");
        expect_at(c0 + 60, 16'h0011, 1'b0, 1'b0, "pause_frozen");
        expect_at(c0 + 72, 16'h0011, 1'b0, 1'b0, "pause_before_resume");
        expect_at(c0 + 73, 16'h0011, 1'b1, 1'b0, "resume");
        expect_at(c0 + 74, 16'h0012, 1'b1, 1'b0, "resume_tick");
        expect_at(c0 + 77, 16'h0012, 1'b1, 1'b0, "post_resume_hold");
        expect_at(c0 + 78, 16'h0013, 1'b1, 1'b0, "post_resume_tick");
        goto(c0 + 47);
        key_ss_n = 1'b0;
        goto(c0 + 55);
        key_ss_n = 1'b1;
        goto(c0 + 70);
        key_ss_n = 1'b0;
        goto(c0 + 75);
        key_ss_n = 1'b1;

        // clr while running is ignored
        expect_at(c0 + 83, 16'h0014, 1'b1, 1'b0, "clr_in_run");
        expect_at(c0 + 86, 16'h0015, 1'b1, 1'b0, "clr_in_run_count");
        goto(c0 + 80);
        key_clr_n = 1'b0;
        goto(c0 + 85);
        key_clr_n = 1'b1;

        // pause, then ss+clr together -> IDLE, then clr in IDLE ignored
        expect_at(c0 + 93,  16'h0016, 1'b0, 1'b0, "pause2");
        expect_at(c0 + 102, 16'h0016, 1'b0, 1'b0, "pause2_hold");
        expect_at(c0 + 103, 16'h0000, 1'b0, 1'b0, "ss_clr_to_idle");
        expect_at(c0 + 104, 16'h0000, 1'b0, 1'b0, "idle_stays");
        expect_at(c0 + 113, 16'h0000, 1'b0, 1'b0, "clr_in_idle");
        goto(c0 + 90);
        key_ss_n = 1'b0;
        goto(c0 + 95);
        key_ss_n = 1'b1;
        goto(c0 + 100);
        key_ss_n = 1'b0; key_clr_n = 1'b0;
        goto(c0 + 106);
        key_ss_n = 1'b1; key_clr_n = 1'b1;
        goto(c0 + 110);
        key_clr_n = 1'b0;
        goto(c0 + 115);
        key_clr_n = 1'b1;

        // lap at 00:03, lap again after 12 cycles
        b3 = c0 + 120;
        goto(b3);
        expect_at(b3 + 15, 16'h0003, 1'b1, 1'b0, "lap_base");
        expect_at(b3 + 17, 16'h0003, 1'b1, 1'b0, "lap_set");
        expect_at(b3 + 19, LAP ? 16'h0003 : 16'h0004, 1'b1, 1'b0, "lap_hold_a");
        expect_at(b3 + 28, LAP ? 16'h0003 : 16'h0006, 1'b1, 1'b0, "lap_hold_b");
        expect_at(b3 + 29, 16'h0006, 1'b1, 1'b0, "lap_release");
        expect_at(b3 + 31, 16'h0007, 1'b1, 1'b0, "lap_live");
        expect_at(b3 + 39, 16'h0009, 1'b0, 1'b0, "lap_pause");
        expect_at(b3 + 47, 16'h0000, 1'b0, 1'b0, "lap_clear");
        key_ss_n = 1'b0;
        goto(b3 + 10);
        key_ss_n = 1'b1;
        goto(b3 + 14);
        key_lap_n = 1'b0;
        goto(b3 + 20);
        key_lap_n = 1'b1;
        goto(b3 + 26);
        key_lap_n = 1'b0;
        goto(b3 + 32);
        key_lap_n = 1'b1;
        goto(b3 + 36);
        key_ss_n = 1'b0;
        goto(b3 + 42);
        key_ss_n = 1'b1;
        goto(b3 + 44);
        key_clr_n = 1'b0;
        goto(b3 + 50);
        key_clr_n = 1'b1;

        // long run through minute carries and the 59:59 wrap, then async reset at 00:07
        b = b3 + 60;
        goto(b);
        expect_at(b + 2399,  16'h0959, 1'b1, 1'b0, "min_carry_pre");
        expect_at(b + 2403,  16'h1000, 1'b1, 1'b0, "min_carry");
        expect_at(b + 14395, 16'h5958, 1'b1, 1'b0, "at_5958");
        expect_at(b + 14399, 16'h5959, 1'b1, 1'b0, "at_5959");
        expect_at(b + 14402, 16'h5959, 1'b1, 1'b0, "pre_wrap");
        expect_at(b + 14403, 16'h0000, 1'b1, 1'b1, "wrap_pulse");
        expect_at(b + 14404, 16'h0000, 1'b1, 1'b0, "wrap_one_cycle");
        expect_at(b + 14407, 16'h0001, 1'b1, 1'b0, "after_wrap");
        expect_at(b + 14431, 16'h0007, 1'b1, 1'b0, "pre_reset");
        expect_at(b + 14432, 16'h0000, 1'b0, 1'b0, "async_reset");
        expect_at(b + 14435, 16'h0000, 1'b0, 1'b0, "reset_release");
        key_ss_n = 1'b0;
        goto(b + 8);
        key_ss_n = 1'b1;
        goto(b + 14432);
        rst = 1'b0;
        #1;
        checks++;
        if (dig !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: got dig=%h run=%b wrap=%b, want dig=0000 run=0 wrap=0",
                     dig, running, wrap);
        end
        goto(b + 14434);
        rst = 1'b1;

        goto(b + 14440);
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no comparison by cyc %0d, want one at cyc %0d",
                     sb[0].name, cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
